// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM access path: arbiter states and bus widths.
package eeprom_pkg;

  localparam int EE_ADDR_W = 16;
  localparam int EE_DATA_W = 32;

  // 7-bit I2C slave address of the EEPROM device on the controller side.
  localparam logic [6:0] SLA7 = 7'h50;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_BUSY,
    ARB_DONE,
    ARB_FAIL
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] winner,
  output logic             valid
);

  logic [PTR_W-1:0] idx;

  // NOTE: every output of a combinational block gets a default before the loop,
  // otherwise paths that assign nothing infer a latch.
  always_comb begin
    winner = rr_ptr;
    valid  = |req;
    idx    = rr_ptr;
    // Walk from the farthest candidate back to rr_ptr so the nearest set bit wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(rr_ptr) + k) % NREQ);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/eeprom_arbiter.sv
// Round-robin arbiter sharing one eeprom_controller between NREQ requesters,
// with issue and busy timeouts reported as a per-requester error pulse.
module eeprom_arbiter
  import eeprom_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int ISSUE_TMO = 4096,
  parameter int BUSY_TMO  = 2000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           wr,
  input  logic [EE_ADDR_W*NREQ-1:0] addr,
  input  logic [EE_DATA_W*NREQ-1:0] wdata,
  output logic [NREQ-1:0]           ack,
  output logic [NREQ-1:0]           err,
  output logic [EE_DATA_W-1:0]      rdata,
  output logic                      busy,
  output logic                      ee_req,
  output logic                      ee_wr,
  output logic [EE_ADDR_W-1:0]      ee_addr,
  output logic [EE_DATA_W-1:0]      ee_din,
  input  logic [EE_DATA_W-1:0]      ee_dout,
  input  logic                      ee_grant
);

  localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMO_MAX = (ISSUE_TMO > BUSY_TMO) ? ISSUE_TMO : BUSY_TMO;
  localparam int CNT_W   = $clog2(TMO_MAX + 1);

  localparam logic [CNT_W-1:0] ISSUE_LAST = CNT_W'(ISSUE_TMO - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(BUSY_TMO - 1);

  arb_state_t       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] pick;
  logic             pick_valid;
  logic [CNT_W-1:0] cnt;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

  // NOTE: all state here is sequential, so only non-blocking assignments are used;
  // later assignments in the same pass (e.g. ack[winner]) override the defaults.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB_IDLE;
      rr_ptr  <= '0;
      winner  <= '0;
      cnt     <= '0;
      ack     <= '0;
      err     <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      ee_req  <= 1'b0;
      ee_wr   <= 1'b0;
      ee_addr <= '0;
      ee_din  <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        ARB_IDLE: begin
          busy <= pick_valid;
          if (pick_valid) begin
            winner  <= pick;
            ee_wr   <= wr[pick];
            ee_addr <= addr[EE_ADDR_W*pick +: EE_ADDR_W];
            ee_din  <= wdata[EE_DATA_W*pick +: EE_DATA_W];
            ee_req  <= 1'b1;
            cnt     <= '0;
            state   <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          // Drop req as soon as grant is seen so the controller does not re-enter.
          if (ee_grant) begin
            ee_req <= 1'b0;
            cnt    <= '0;
            state  <= ARB_BUSY;
          end else if (cnt == ISSUE_LAST) begin
            ee_req <= 1'b0;
            state  <= ARB_FAIL;
          end else begin
            cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
          end
        end
        ARB_BUSY: begin
          if (!ee_grant) begin
            // Writes return the data that was written rather than the read bus.
            rdata <= ee_wr ? ee_din : ee_dout;
            state <= ARB_DONE;
          end else if (cnt == BUSY_LAST) begin
            state <= ARB_FAIL;
          end else begin
            cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
          end
        end
        ARB_DONE: begin
          ack[winner] <= 1'b1;
          rr_ptr      <= (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;
          state       <= ARB_IDLE;
        end
        ARB_FAIL: begin
          err[winner] <= 1'b1;
          rr_ptr      <= (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;
          state       <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Self-checking bench for eeprom_arbiter: directed scenarios plus randomized traffic
// against a round-robin reference model and a behavioural controller model.
module tb_eeprom_arbiter;

  localparam int NREQ      = 2;
  localparam int ISSUE_TMO = 16;
  localparam int BUSY_TMO  = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  wr;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [31:0] rdata;
  logic        busy;
  logic        ee_req;
  logic        ee_wr;
  logic [15:0] ee_addr;
  logic [31:0] ee_din;
  logic [31:0] ee_dout;
  logic        ee_grant;

  eeprom_arbiter #(
    .NREQ      (NREQ),
    .ISSUE_TMO (ISSUE_TMO),
    .BUSY_TMO  (BUSY_TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .ack      (ack),
    .err      (err),
    .rdata    (rdata),
    .busy     (busy),
    .ee_req   (ee_req),
    .ee_wr    (ee_wr),
    .ee_addr  (ee_addr),
    .ee_din   (ee_din),
    .ee_dout  (ee_dout),
    .ee_grant (ee_grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Cycle counters for the controller handshake lines.
  int unsigned req_hi_total   = 0;
  int unsigned grant_hi_total = 0;
  always @(posedge clk) begin
    if (ee_req === 1'b1)   req_hi_total   <= req_hi_total + 1;
    if (ee_grant === 1'b1) grant_hi_total <= grant_hi_total + 1;
  end

  // Controller model knobs: c_delay<0 never grants, c_hold<0 holds grant until abort.
  int          c_delay = 0;
  int          c_hold  = 1;
  logic [31:0] c_rdval = '0;
  bit          c_abort = 1'b0;
  bit          ctrl_busy = 1'b0;
  logic [15:0] g_addr;
  logic [31:0] g_din;
  logic        g_wr;
  logic [15:0] d_addr;
  logic [31:0] d_din;

  initial begin
    ee_grant = 1'b0;
    ee_dout  = '0;
    forever begin
      @(posedge clk); #1;
      if (ee_req === 1'b1 && reset === 1'b0) begin
        ctrl_busy = 1'b1;
        if (c_delay < 0) begin
          while (!c_abort) begin @(posedge clk); #1; end
        end else begin
          repeat (c_delay) begin @(posedge clk); #1; end
          ee_grant = 1'b1;
          g_addr = ee_addr;
          g_din  = ee_din;
          g_wr   = ee_wr;
          if (c_hold < 0) begin
            while (!c_abort) begin @(posedge clk); #1; end
          end else begin
            repeat (c_hold) begin @(posedge clk); #1; end
          end
          d_addr = ee_addr;
          d_din  = ee_din;
          if (!c_abort) ee_dout = ee_wr ? ee_din : c_rdval;
          ee_grant = 1'b0;
        end
        ctrl_busy = 1'b0;
      end
    end
  end

  // Reference model state: round-robin pointer and last returned data.
  int          m_ptr   = 0;
  logic [31:0] m_rdata = '0;

  function automatic int exp_winner(input logic [1:0] mask, input int ptr);
    for (int i = 0; i < NREQ; i++)
      if (mask[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_check(input string tag, input bit ok);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s: observed=timeout expected=event", tag);
    end
  endtask

  task automatic wait_done(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ((|ack) || (|err)) begin ok = 1'b1; break; end
    end
    bound_check({tag, "/done_wait"}, ok);
  endtask

  task automatic abort_ctrl(input string tag);
    bit ok;
    c_abort = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!ctrl_busy) begin ok = 1'b1; break; end
    end
    c_abort = 1'b0;
    bound_check({tag, "/ctrl_idle"}, ok);
  endtask

  task automatic expect_ack(input string tag, input logic [1:0] next_mask);
    int          w;
    int unsigned r0;
    bit          ok;
    logic [31:0] exp_rd;
    w  = exp_winner(req, m_ptr);
    r0 = req_hi_total;
    exp_rd = wr[w] ? wdata[32*w +: 32] : c_rdval;
    wait_done(tag, ok);
    if (ok) begin
      check({tag, "/ack"}, 64'(ack), 64'(1) << w);
      check({tag, "/err"}, 64'(err), 64'(0));
      check({tag, "/rdata"}, 64'(rdata), 64'(exp_rd));
      check({tag, "/ee_addr"}, 64'(g_addr), 64'(addr[16*w +: 16]));
      check({tag, "/ee_din"}, 64'(g_din), 64'(wdata[32*w +: 32]));
      check({tag, "/ee_wr"}, 64'(g_wr), 64'(wr[w]));
      check({tag, "/addr_stable"}, 64'(d_addr), 64'(addr[16*w +: 16]));
      check({tag, "/din_stable"}, 64'(d_din), 64'(wdata[32*w +: 32]));
      check({tag, "/ee_req_cycles"}, 64'(req_hi_total - r0), 64'(c_delay + 1));
      m_rdata = exp_rd;
    end
    m_ptr = (w + 1) % NREQ;
    req = next_mask;
    @(negedge clk);
    check({tag, "/ack_pulse"}, 64'(ack), 64'(0));
    if (next_mask == 2'b00) check({tag, "/busy_low"}, 64'(busy), 64'(0));
  endtask

  task automatic expect_err(input string tag, input bit issue_kind);
    int          w;
    int unsigned r0;
    int unsigned g0;
    int unsigned gd;
    bit          ok;
    w  = exp_winner(req, m_ptr);
    r0 = req_hi_total;
    g0 = grant_hi_total;
    wait_done(tag, ok);
    if (ok) begin
      check({tag, "/err"}, 64'(err), 64'(1) << w);
      check({tag, "/ack"}, 64'(ack), 64'(0));
      check({tag, "/rdata_kept"}, 64'(rdata), 64'(m_rdata));
      if (issue_kind) begin
        check({tag, "/ee_req_cycles"}, 64'(req_hi_total - r0), 64'(ISSUE_TMO));
      end else begin
        gd = grant_hi_total - g0;
        check({tag, "/busy_tmo_min"}, 64'(gd >= BUSY_TMO), 64'(1));
        check({tag, "/busy_tmo_max"}, 64'(gd <= BUSY_TMO + 3), 64'(1));
      end
    end
    m_ptr = (w + 1) % NREQ;
    req = 2'b00;
    @(negedge clk);
    check({tag, "/err_pulse"}, 64'(err), 64'(0));
    check({tag, "/busy_low"}, 64'(busy), 64'(0));
    abort_ctrl(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ptr   = 0;
    m_rdata = '0;
  endtask

  initial begin
    logic [1:0] m;
    bit         ok;
    reset = 1'b1;
    req   = '0;
    wr    = '0;
    addr  = '0;
    wdata = '0;
    repeat (2) @(negedge clk);
    check("rst/ack", 64'(ack), 64'(0));
    check("rst/err", 64'(err), 64'(0));
    check("rst/rdata", 64'(rdata), 64'(0));
    check("rst/busy", 64'(busy), 64'(0));
    check("rst/ee_req", 64'(ee_req), 64'(0));
    check("rst/ee_wr", 64'(ee_wr), 64'(0));
    check("rst/ee_addr", 64'(ee_addr), 64'(0));
    check("rst/ee_din", 64'(ee_din), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Single read with a 50-cycle grant envelope.
    c_delay = 3; c_hold = 50; c_rdval = 32'hDEADBEEF;
    addr = {16'h0000, 16'h0010}; wr = 2'b00;
    req = 2'b01;
    expect_ack("read1", 2'b00);

    // Both requesters held continuously from reset: service alternates 0,1,0,1.
    do_reset();
    c_delay = 1; c_hold = 4; c_rdval = 32'hA5A5_0001;
    addr = {16'h0200, 16'h0100}; wdata = {32'h1111_2222, 32'h3333_4444};
    req = 2'b11;
    expect_ack("alt0", 2'b11);
    expect_ack("alt1", 2'b11);
    expect_ack("alt2", 2'b11);
    expect_ack("alt3", 2'b00);

    // Write from requester 1: data mirrored back on rdata.
    c_delay = 2; c_hold = 8;
    wr = 2'b10; addr = {16'h7FFC, 16'h0000}; wdata = {32'h12345678, 32'h0};
    req = 2'b10;
    expect_ack("write1", 2'b00);

    // Controller never grants: issue timeout.
    c_delay = -1; wr = 2'b00;
    req = 2'b01;
    expect_err("issue_tmo", 1'b1);

    // Grant stuck high: busy timeout, then a normal request is still served.
    c_delay = 1; c_hold = -1;
    req = 2'b10;
    expect_err("busy_tmo", 1'b0);
    c_hold = 6; c_rdval = 32'hCAFE_F00D;
    req = 2'b01;
    expect_ack("after_tmo", 2'b00);

    // Randomized traffic.
    for (int t = 0; t < 24; t++) begin
      m = 2'($urandom_range(1, 3));
      wr = 2'($urandom);
      addr = {16'($urandom), 16'($urandom)};
      wdata = {$urandom, $urandom};
      c_delay = int'($urandom_range(0, 6));
      c_hold  = int'($urandom_range(1, 12));
      c_rdval = $urandom;
      req = m;
      expect_ack("rand", 2'b00);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of a BUSY phase, with rr_ptr pointing at requester 1.
    c_delay = 1; c_hold = 3; wr = 2'b00;
    req = 2'b01;
    expect_ack("pre_rst", 2'b00);
    c_hold = -1;
    req = 2'b10;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ee_grant) begin ok = 1'b1; break; end
    end
    bound_check("mid_rst/grant_wait", ok);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst/ee_req", 64'(ee_req), 64'(0));
    check("mid_rst/busy", 64'(busy), 64'(0));
    check("mid_rst/ack", 64'(ack), 64'(0));
    check("mid_rst/err", 64'(err), 64'(0));
    check("mid_rst/rdata", 64'(rdata), 64'(0));
    reset = 1'b0;
    req = 2'b00;
    m_ptr = 0;
    m_rdata = '0;
    abort_ctrl("mid_rst");
    repeat (2) @(negedge clk);
    c_hold = 4; c_rdval = 32'h0BAD_C0DE;
    req = 2'b11;
    expect_ack("post_rst", 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
